usb_tx_encoder: RTL and testbench



---
 rtl/usb_tx_encoder.sv | 186 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB NRZI transmit encoder with SYNC, bit stuffing and EOP generation
// Bytes go out LSB first behind an 8'h80 SYNC; a stuffed 0 follows every run of six 1s.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    ones_q, ones_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_last_q, hold_last_d;
    logic          last_q, last_d;
    logic          stuff_q, stuff_d;
    logic          dp_q, dp_d;
    logic          dm_q, dm_d;
    logic          done_q, done_d;

    logic          wrap;
    logic          byte_end;
    logic          send_en;
    logic          send_val;
    logic [2:0]    nxt_idx;

    assign wrap     = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign nxt_idx  = idx_q + 3'd1;
    // A byte is finished once bit 7 is out and no stuffed bit is still owed.
    assign byte_end = (state_q == DATA) && wrap && (idx_q == 3'd7) && (ones_q != 3'd6);

    assign d_plus  = dp_q;
    assign d_minus = dm_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = wrap ? '0 : cnt_q + CW'(1);
        idx_d       = idx_q;
        ones_d      = ones_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        last_d      = last_q;
        stuff_d     = stuff_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        done_d      = 1'b0;
        send_en     = 1'b0;
        send_val    = 1'b0;
        tx_ready    = (state_q == IDLE) || (byte_end && !last_q);
        tx_error    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    hold_d      = tx_data;
                    hold_last_d = tx_last;
                    idx_d       = 3'd0;
                    state_d     = SYNC;
                    send_en     = 1'b1;
                end
            end
            SYNC: begin
                if (wrap) begin
                    send_en = 1'b1;
                    if (idx_q != 3'd7) begin
                        idx_d    = nxt_idx;
                        send_val = (idx_q == 3'd6);
                    end else begin
                        shift_d  = hold_q;
                        last_d   = hold_last_q;
                        idx_d    = 3'd0;
                        stuff_d  = 1'b0;
                        state_d  = DATA;
                        send_val = hold_q[0];
                    end
                end
            end
            DATA: begin
                if (wrap) begin
                    if (ones_q == 3'd6) begin
                        stuff_d = 1'b1;
                        send_en = 1'b1;
                    end else if (idx_q != 3'd7) begin
                        idx_d    = nxt_idx;
                        stuff_d  = 1'b0;
                        send_en  = 1'b1;
                        send_val = shift_q[nxt_idx];
                    end else if (!last_q && tx_valid) begin
                        shift_d  = tx_data;
                        last_d   = tx_last;
                        idx_d    = 3'd0;
                        stuff_d  = 1'b0;
                        send_en  = 1'b1;
                        send_val = tx_data[0];
                    end else begin
                        tx_error = !last_q;
                        idx_d    = 3'd0;
                        state_d  = EOP_SE0;
                        dp_d     = 1'b0;
                        dm_d     = 1'b0;
                    end
                end
            end
            EOP_SE0: begin
                if (wrap) begin
                    if (idx_q == 3'd1) begin
                        idx_d   = 3'd0;
                        state_d = EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        idx_d = 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ones_d  = 3'd0;
                    stuff_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // NRZI: a 0 flips between J and K, a 1 keeps the line where it is.
        if (send_en) begin
            ones_d = send_val ? ones_q + 3'd1 : 3'd0;
            if (!send_val) begin
                dp_d = ~dp_q;
                dm_d = dp_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            ones_q      <= 3'd0;
            shift_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_last_q <= 1'b0;
            last_q      <= 1'b0;
            stuff_q     <= 1'b0;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            last_q      <= last_d;
            stuff_q     <= stuff_d;
            dp_q        <= dp_d;
            dm_q        <= dm_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb/tb_usb_tx_encoder.sv - self-checking bench for usb_tx_encoder
// Expected line activity comes from a bit-list model: SYNC + data, stuffing, NRZI, EOP.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] pk [0:7];
    logic [1:0] exp_line [$];
    int         rdy_at [$];
    int         err_at;

    // Vector layout: {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}
    localparam logic [5:0] IDLE_VEC = 6'b10_0100;

    task automatic build_model(input int n, input bit underrun);
        bit         bits [$];
        int         ones;
        logic [1:0] lvl;
        logic [7:0] syncb;
        bit         b;
        ones  = 0;
        lvl   = 2'b10;
        syncb = 8'h80;
        exp_line.delete();
        rdy_at.delete();
        err_at = -1;
        for (int k = -1; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = (k < 0) ? syncb[i] : pk[k][i];
                bits.push_back(b);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
            if (k >= 0 && (k != n - 1 || underrun))
                rdy_at.push_back(bits.size() * CPB);
        end
        if (underrun)
            err_at = bits.size() * CPB;
        foreach (bits[i]) begin
            if (!bits[i])
                lvl = (lvl == 2'b10) ? 2'b01 : 2'b10;
            repeat (CPB) exp_line.push_back(lvl);
        end
        repeat (2 * CPB) exp_line.push_back(2'b00);
        repeat (CPB) exp_line.push_back(2'b10);
    endtask

    task automatic run_packet(input int n, input bit underrun, input bit pre,
                              input bit chain, input logic [7:0] chain_byte, input string name);
        int         tlen;
        int         k;
        bit         exp_rdy;
        bit         exp_err;
        logic [5:0] got;
        logic [5:0] exp;
        build_model(n, underrun);
        tlen = exp_line.size();
        if (!pre) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = pk[0];
            tx_last  = (n == 1) && !underrun;
            #1;
            got = {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error};
            n_tests++;
            if (got !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL %s idle-before-start: got %b expected %b", name, got, IDLE_VEC);
            end
        end
        k = 1;
        for (int t = 1; t <= tlen + 1; t++) begin
            @(negedge clk);
            exp_rdy = (rdy_at.size() > 0 && rdy_at[0] == t);
            exp_err = (t == err_at);
            if (exp_rdy)
                void'(rdy_at.pop_front());
            if (t == tlen + 1) begin
                tx_valid = chain;
                tx_data  = chain_byte;
                tx_last  = 1'b1;
            end else if (exp_rdy) begin
                if (k < n) begin
                    tx_valid = 1'b1;
                    tx_data  = pk[k];
                    tx_last  = (k == n - 1) && !underrun;
                    k++;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                tx_last  = 1'($urandom);
            end
            #1;
            if (t <= tlen)
                exp = {exp_line[t-1], 1'b1, exp_rdy, 1'b0, exp_err};
            else
                exp = 6'b10_0110;
            got = {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, t, got, exp);
            end
        end
        if (!chain)
            tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got5;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        tx_last  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        got5 = {d_plus, d_minus, tx_busy, tx_done, tx_error};
        n_tests++;
        if (got5 !== 5'b10_000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", got5, 5'b10_000);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error} !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b",
                     {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error}, IDLE_VEC);
        end
    endtask

    task automatic test_single_zero();
        pk[0] = 8'h00;
        run_packet(1, 1'b0, 1'b0, 1'b0, 8'h00, "single_00");
    endtask

    task automatic test_single_ff();
        pk[0] = 8'hFF;
        run_packet(1, 1'b0, 1'b0, 1'b0, 8'h00, "single_ff");
    endtask

    task automatic test_two_bytes();
        pk[0] = 8'h3F;
        pk[1] = 8'h81;
        run_packet(2, 1'b0, 1'b0, 1'b0, 8'h00, "two_3f_81");
    endtask

    task automatic test_underrun();
        pk[0] = 8'h12;
        run_packet(1, 1'b1, 1'b0, 1'b0, 8'h00, "underrun_12");
    endtask

    task automatic test_random();
        int n;
        bit ur;
        for (int p = 0; p < 8; p++) begin
            n  = $urandom_range(1, 4);
            ur = 1'($urandom);
            for (int i = 0; i < n; i++)
                pk[i] = ((p % 3) == 0) ? 8'hFF ^ 8'($urandom_range(0, 3)) : 8'($urandom);
            run_packet(n, ur, 1'b0, 1'b0, 8'h00, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] second;
        second = 8'($urandom);
        pk[0]  = 8'($urandom);
        run_packet(1, 1'b0, 1'b0, 1'b1, second, "b2b_first");
        pk[0] = second;
        run_packet(1, 1'b0, 1'b1, 1'b0, 8'h00, "b2b_second");
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tx_last  = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (91) @(negedge clk);
        #1;
        n_tests++;
        if (tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: got %b expected 1", tx_busy);
        end
        rst = 1'b1;
        #1;
        got = {d_plus, d_minus, tx_busy, 1'b0, tx_done, tx_error};
        n_tests++;
        if (got !== 6'b10_0000) begin
            n_fail++;
            $display("FAIL midrst_abort: got %b expected %b", got, 6'b10_0000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            #1;
            got = {d_plus, d_minus, tx_busy, tx_ready, tx_done, tx_error};
            n_tests++;
            if (got !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL midrst_idle cycle %0d: got %b expected %b", t, got, IDLE_VEC);
            end
        end
        pk[0] = 8'hFF;
        run_packet(1, 1'b0, 1'b0, 1'b0, 8'h00, "after_midrst");
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_single_ff();
        test_two_bytes();
        test_underrun();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
